// File: rtl/alu_issue_stage.sv
// Issue stage ahead of the 32-bit CLA ALU: decodes ALUOp/funct into slice controls
// and presents them through a 2-entry skid buffer with a flop-driven in_ready.
module alu_issue_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_alu_op,
    input  logic [5:0]       in_funct,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_binv,
    output logic             out_cin,
    output logic [1:0]       out_sel,
    output logic             out_illegal,
    output logic [CNT_W-1:0] issued_cnt
);

    // State bits double as the valid bits: [1] = skid valid, [0] = main valid.
    localparam logic [1:0] S_EMPTY = 2'b00;
    localparam logic [1:0] S_ONE   = 2'b01;
    localparam logic [1:0] S_FULL  = 2'b11;

    localparam int PW = 2 * WIDTH + 4;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_in_hs;
    logic             w_out_hs;
    logic             w_load_main_in;
    logic             w_load_main_skid;
    logic             w_load_skid;
    logic             w_dec_binv;
    logic [1:0]       w_dec_sel;
    logic             w_dec_illegal;
    logic [PW-1:0]    w_dec_word;
    logic [PW-1:0]    r_main;
    logic [PW-1:0]    r_skid;
    logic [CNT_W-1:0] r_cnt;

    assign in_ready  = ~r_state[1];
    assign out_valid = r_state[0];
    assign w_in_hs   = in_valid & ~r_state[1];
    assign w_out_hs  = r_state[0] & out_ready;

    always_comb begin
        w_dec_binv    = 1'b0;
        w_dec_sel     = 2'b10;
        w_dec_illegal = 1'b0;
        case (in_alu_op)
            2'b00: w_dec_binv = 1'b0;
            2'b01: w_dec_binv = 1'b1;
            2'b10: begin
                case (in_funct)
                    6'b100000: w_dec_binv = 1'b0;
                    6'b100010: w_dec_binv = 1'b1;
                    6'b100100: w_dec_sel  = 2'b00;
                    6'b100101: w_dec_sel  = 2'b01;
                    6'b101010: begin
                        w_dec_binv = 1'b1;
                        w_dec_sel  = 2'b11;
                    end
                    default:   w_dec_illegal = 1'b1;
                endcase
            end
            default: w_dec_illegal = 1'b1;
        endcase
    end

    assign w_dec_word = {in_a, in_b, w_dec_binv, w_dec_sel, w_dec_illegal};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_EMPTY;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_in_hs) w_state_nxt = S_ONE;
            S_ONE: begin
                if (w_in_hs && !w_out_hs)      w_state_nxt = S_FULL;
                else if (!w_in_hs && w_out_hs) w_state_nxt = S_EMPTY;
            end
            S_FULL:  if (w_out_hs) w_state_nxt = S_ONE;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            S_EMPTY: w_load_main_in = w_in_hs;
            S_ONE: begin
                w_load_main_in = w_in_hs & w_out_hs;
                w_load_skid    = w_in_hs & ~w_out_hs;
            end
            S_FULL:  w_load_main_skid = w_out_hs;
            default: w_load_main_in = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in)        r_main <= w_dec_word;
            else if (w_load_main_skid) r_main <= r_skid;
            if (w_load_skid)           r_skid <= w_dec_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_cnt <= '0;
        else if (w_out_hs) r_cnt <= r_cnt + CNT_W'(1);
    end

    assign out_a       = r_main[PW-1 -: WIDTH];
    assign out_b       = r_main[WIDTH+3 -: WIDTH];
    assign out_binv    = r_main[3];
    assign out_cin     = r_main[3];
    assign out_sel     = r_main[2:1];
    assign out_illegal = r_main[0];
    assign issued_cnt  = r_cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: queue-based reference model of the decode
// table and FIFO ordering, plus a CNT_W=4 instance sharing the stimulus for wrap.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        binv;
        logic        cin;
        logic [1:0]  sel;
        logic        ill;
    } item_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_alu_op;
    logic [5:0]  in_funct;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic        out_binv;
    logic        out_cin;
    logic [1:0]  out_sel;
    logic        out_illegal;
    logic [15:0] issued_cnt;

    logic        in_ready_4;
    logic        out_valid_4;
    logic [31:0] out_a_4;
    logic [31:0] out_b_4;
    logic        out_binv_4;
    logic        out_cin_4;
    logic [1:0]  out_sel_4;
    logic        out_illegal_4;
    logic [3:0]  issued_cnt_4;

    int n_tests = 0;
    int n_fail  = 0;
    int n_hs    = 0;
    item_t q_exp[$];
    item_t q_obs[$];

    alu_issue_stage #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_funct(in_funct), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_binv(out_binv), .out_cin(out_cin), .out_sel(out_sel),
        .out_illegal(out_illegal), .issued_cnt(issued_cnt)
    );

    alu_issue_stage #(.WIDTH(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_4),
        .in_alu_op(in_alu_op), .in_funct(in_funct), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid_4), .out_ready(out_ready), .out_a(out_a_4), .out_b(out_b_4),
        .out_binv(out_binv_4), .out_cin(out_cin_4), .out_sel(out_sel_4),
        .out_illegal(out_illegal_4), .issued_cnt(issued_cnt_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference decode straight from the ALUOp/funct table.
    function automatic item_t ref_op(logic [1:0] op, logic [5:0] f, logic [31:0] a, logic [31:0] b);
        item_t it;
        it.a = a; it.b = b; it.binv = 1'b0; it.sel = 2'b10; it.ill = 1'b0;
        if (op == 2'b01) it.binv = 1'b1;
        else if (op == 2'b11) it.ill = 1'b1;
        else if (op == 2'b10) begin
            if (f == 6'd32) it.binv = 1'b0;
            else if (f == 6'd34) it.binv = 1'b1;
            else if (f == 6'd36) it.sel = 2'b00;
            else if (f == 6'd37) it.sel = 2'b01;
            else if (f == 6'd42) begin it.binv = 1'b1; it.sel = 2'b11; end
            else it.ill = 1'b1;
        end
        it.cin = it.binv;
        return it;
    endfunction

    function automatic item_t cur_out();
        item_t it;
        it.a = out_a; it.b = out_b; it.binv = out_binv; it.cin = out_cin;
        it.sel = out_sel; it.ill = out_illegal;
        return it;
    endfunction

    function automatic int occ();
        return q_exp.size() - q_obs.size();
    endfunction

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = v; in_alu_op = op; in_funct = f; in_a = a; in_b = b;
    endtask

    // Monitor: records both handshakes of the current cycle, ends at the next negedge.
    task automatic run_cycle(output bit ih, output bit oh);
        #1;
        ih = in_valid && in_ready;
        oh = out_valid && out_ready;
        if (oh) begin
            q_obs.push_back(cur_out());
            n_hs++;
        end
        if (ih) q_exp.push_back(ref_op(in_alu_op, in_funct, in_a, in_b));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        bit ih, oh;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && occ() != 0; k++) run_cycle(ih, oh);
        n_tests++;
        if (occ() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: occupancy %0d, required 0", occ());
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q_exp.delete(); q_obs.delete(); n_hs = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b0;
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        #3;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
        n_tests++;
        if (issued_cnt !== 16'd0 || cur_out() !== item_t'(0)) begin
            n_fail++;
            $display("FAIL reset_payload: cnt=%0d payload=%h, required 0/0", issued_cnt, cur_out());
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_decode_sweep();
        logic [5:0] fn [5];
        logic [2:0] bs [5];
        bit ih, oh;
        fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        bs = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        q_exp.delete(); q_obs.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b10, fn[i], 32'd5, 32'd3);
            run_cycle(ih, oh);
        end
        drain();
        n_tests++;
        if (q_obs.size() != 5) begin
            n_fail++;
            $display("FAIL decode_count: got %0d ops, required 5", q_obs.size());
        end
        for (int i = 0; i < 5 && i < q_obs.size(); i++) begin
            n_tests++;
            if ({q_obs[i].binv, q_obs[i].sel} !== bs[i] || q_obs[i].cin !== bs[i][2] ||
                q_obs[i].ill !== 1'b0 || q_obs[i].a !== 32'd5 || q_obs[i].b !== 32'd3) begin
                n_fail++;
                $display("FAIL decode_funct%0d: got binv/sel=%b cin=%b ill=%b, required %b cin=%b ill=0",
                         i, {q_obs[i].binv, q_obs[i].sel}, q_obs[i].cin, q_obs[i].ill, bs[i], bs[i][2]);
            end
        end
    endtask

    task automatic test_illegal();
        bit ih, oh;
        q_exp.delete(); q_obs.delete();
        out_ready = 1'b1;
        drive(1'b1, 2'b00, 6'd0, 32'd10, 32'd20);  run_cycle(ih, oh);
        drive(1'b1, 2'b11, 6'd32, 32'd11, 32'd21); run_cycle(ih, oh);
        drive(1'b1, 2'b10, 6'd0, 32'd12, 32'd22);  run_cycle(ih, oh);
        drive(1'b1, 2'b01, 6'd0, 32'd13, 32'd23);  run_cycle(ih, oh);
        drain();
        n_tests++;
        if (q_obs.size() != 4 || q_obs != q_exp) begin
            n_fail++;
            $display("FAIL illegal_stream: got %0d ops, required %0d matching the model", q_obs.size(), q_exp.size());
        end
        if (q_obs.size() == 4) begin
            n_tests++;
            if (q_obs[1].ill !== 1'b1 || q_obs[2].ill !== 1'b1 || q_obs[1].sel !== 2'b10 ||
                q_obs[1].binv !== 1'b0 || q_obs[0].ill !== 1'b0 || q_obs[2].a !== 32'd12) begin
                n_fail++;
                $display("FAIL illegal_flags: got ill=%b%b%b sel=%b binv=%b, required ill=011 sel=10 binv=0",
                         q_obs[0].ill, q_obs[1].ill, q_obs[2].ill, q_obs[1].sel, q_obs[1].binv);
            end
        end
    endtask

    task automatic test_throughput();
        bit ih, oh;
        int drops = 0;
        q_exp.delete(); q_obs.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 2'b00, 6'd0, 32'(i), 32'(2 * i));
            run_cycle(ih, oh);
            if (!ih) drops++;
        end
        in_valid = 1'b0;
        run_cycle(ih, oh);
        n_tests++;
        if (drops != 0) begin
            n_fail++;
            $display("FAIL throughput_in_ready: %0d stalled cycles, required 0", drops);
        end
        n_tests++;
        if (q_obs.size() != 100 || q_obs != q_exp) begin
            n_fail++;
            $display("FAIL throughput_stream: got %0d ops one cycle after the last accept, required 100 in order", q_obs.size());
        end
        n_tests++;
        if (issued_cnt !== 16'd100 || issued_cnt_4 !== 4'd4) begin
            n_fail++;
            $display("FAIL throughput_cnt: got %0d/%0d, required 100/4", issued_cnt, issued_cnt_4);
        end
    endtask

    task automatic test_backpressure();
        item_t p [3];
        bit ih, oh;
        int idx = 0;
        q_exp.delete(); q_obs.delete();
        for (int i = 0; i < 3; i++) p[i] = ref_op(2'b10, 6'd37, $urandom, $urandom);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 2'b10, 6'd37, p[idx].a, p[idx].b);
            run_cycle(ih, oh);
            if (ih) idx++;
            if (c >= 2) begin
                n_tests++;
                if (idx != 2 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_a !== p[0].a || out_b !== p[0].b) begin
                    n_fail++;
                    $display("FAIL backpressure_hold: accepted=%0d in_ready=%b out_a=%h, required 2/0/%h",
                             idx, in_ready, out_a, p[0].a);
                end
            end
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10 && idx < 3; c++) begin
            drive(1'b1, 2'b10, 6'd37, p[idx].a, p[idx].b);
            run_cycle(ih, oh);
            if (ih) idx++;
        end
        drain();
        n_tests++;
        if (q_obs.size() != 3 || q_obs[0] !== p[0] || q_obs[1] !== p[1] || q_obs[2] !== p[2]) begin
            n_fail++;
            $display("FAIL backpressure_order: got %0d ops, required op0,op1,op2 in order", q_obs.size());
        end
    endtask

    task automatic test_random();
        bit ih = 1'b1, oh;
        logic [5:0] legal [5];
        int bad = 0;
        legal = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
        q_exp.delete(); q_obs.delete();
        for (int c = 0; c < 400; c++) begin
            if (ih || !in_valid) begin
                if ($urandom_range(9) < 7)
                    drive(1'b1, 2'($urandom_range(3)),
                          ($urandom_range(3) != 0) ? legal[$urandom_range(4)] : 6'($urandom),
                          $urandom, $urandom);
                else
                    in_valid = 1'b0;
            end
            out_ready = ($urandom_range(9) < 6);
            run_cycle(ih, oh);
            n_tests++;
            if (out_valid !== (occ() != 0) || in_ready !== (occ() < 2) ||
                issued_cnt !== 16'(n_hs) || issued_cnt_4 !== 4'(n_hs)) begin
                n_fail++; bad++;
                if (bad < 5)
                    $display("FAIL random_ctrl: out_valid=%b in_ready=%b cnt=%0d cnt4=%0d, required %b/%b/%0d/%0d",
                             out_valid, in_ready, issued_cnt, issued_cnt_4,
                             occ() != 0, occ() < 2, 16'(n_hs), 4'(n_hs));
            end
            if (occ() != 0) begin
                n_tests++;
                if (cur_out() !== q_exp[q_obs.size()]) begin
                    n_fail++; bad++;
                    if (bad < 5)
                        $display("FAIL random_payload: got %h, required %h", cur_out(), q_exp[q_obs.size()]);
                end
            end
        end
        drain();
        n_tests++;
        if (q_obs != q_exp) begin
            n_fail++;
            $display("FAIL random_stream: got %0d ops, required %0d identical to input", q_obs.size(), q_exp.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ih, oh;
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 6'd0, 32'hAAAA_0001, 32'h5555_0001); run_cycle(ih, oh);
        drive(1'b1, 2'b01, 6'd0, 32'hAAAA_0002, 32'h5555_0002); run_cycle(ih, oh);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || issued_cnt !== 16'd0 || out_a !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_async: out_valid=%b in_ready=%b cnt=%0d out_a=%h, required 0/1/0/0",
                     out_valid, in_ready, issued_cnt, out_a);
        end
        q_exp.delete(); q_obs.delete(); n_hs = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 2'b10, 6'd42, 32'd7, 32'd9); run_cycle(ih, oh);
        drain();
        n_tests++;
        if (q_obs.size() != 1 || q_obs != q_exp || issued_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL reset_discard: got %0d ops cnt=%0d, required 1 op cnt=1", q_obs.size(), issued_cnt);
        end
    endtask

    task automatic test_wrap();
        bit ih, oh;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 2'b00, 6'd0, 32'(i), 32'(i));
            run_cycle(ih, oh);
        end
        drain();
        n_tests++;
        if (issued_cnt_4 !== 4'd1 || issued_cnt !== 16'd17) begin
            n_fail++;
            $display("FAIL counter_wrap: got cnt4=%0d cnt16=%0d, required 1/17", issued_cnt_4, issued_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_decode_sweep();
        test_illegal();
        do_reset();
        test_throughput();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Pipeline stage directly upstream of the 32-bit ALU built from the 1-bit CLA ALU slices.
- Accepts operand pairs with MIPS ALUOp/funct, decodes them into slice controls (binv, sel1, sel0, cin), and registers the result.
- Presents registered controls and operands to the ALU through a valid/ready handshake.
- A 2-entry skid buffer sustains one op per cycle with a fully registered in_ready.

Parameters:
- WIDTH, 32, operand width in bits.
- CNT_W, 16, width of the issued-operation counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream offers an op
- in_ready  output  1  stage can accept; equals NOT skid_valid, driven directly from a flop
- in_alu_op  input  2  00 add, 01 sub, 10 R-type (use funct), 11 reserved
- in_funct  input  6  MIPS funct field
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- out_valid  output  1  op available to ALU
- out_ready  input  1  ALU consumes op
- out_a  output  WIDTH  registered operand A
- out_b  output  WIDTH  registered operand B
- out_binv  output  1  B-invert to every slice
- out_cin  output  1  carry-in to slice 0; always equals out_binv
- out_sel  output  2  {sel1,sel0}: 00 AND, 01 OR, 10 SUM, 11 LESS
- out_illegal  output  1  op was undecodable
- issued_cnt  output  CNT_W  count of completed output handshakes

Behaviour:
- Handshakes:
  - Input handshake: in_valid & in_ready.
  - Output handshake: out_valid & out_ready.
  - Data is captured only on a handshake.
- Decode, applied at capture:
  - alu_op 00 -> binv 0, sel 10.
  - alu_op 01 -> binv 1, sel 10.
  - alu_op 10, funct 100000 -> binv 0, sel 10.
  - alu_op 10, funct 100010 -> binv 1, sel 10.
  - alu_op 10, funct 100100 -> binv 0, sel 00.
  - alu_op 10, funct 100101 -> binv 0, sel 01.
  - alu_op 10, funct 101010 -> binv 1, sel 11.
  - Any other funct, or alu_op 11 -> binv 0, sel 10, illegal 1.
  - Illegal ops still pass through in order. They are not dropped.
- Storage: a main register drives the outputs; a skid register holds one extra entry. Each register has its own valid bit.
- States: EMPTY (main invalid), ONE (main valid, skid invalid), FULL (both valid).
  - EMPTY + input handshake -> ONE, main loaded.
  - ONE + input handshake only -> FULL, skid loaded.
  - ONE + output handshake only -> EMPTY.
  - ONE + both handshakes in the same cycle -> ONE, main reloaded with the new op.
  - FULL: in_ready=0, so no input handshake can occur. Output handshake -> ONE, main takes the skid contents.
- Ordering: strict FIFO. Zero bubbles when out_ready stays high.
- Latency: an op accepted at edge N appears on the outputs after edge N (same cycle as out_valid), when the stage was EMPTY.
- Payload stability: while out_valid=1 and out_ready=0, all out_* payloads hold stable.
- Counter: issued_cnt increments by 1 on each output handshake. Wraps from 2^CNT_W-1 to 0.
- Reset (asynchronous assert, synchronous release):
  - Both valid bits cleared.
  - All out_* payloads = 0.
  - issued_cnt = 0.
  - in_ready = 1 during and after reset.
  - A reset mid-operation discards both entries silently.
- in_valid is ignored while in_ready=0. Upstream must hold its data.
- No combinational path from any input to in_ready.

Test Plan:
- Reset: rst_n low mid-stream with two ops held -> out_valid=0, in_ready=1, issued_cnt=0 asynchronously, before the next edge.
- Decode sweep: alu_op=10 with funct 100000/100010/100100/100101/101010, a=5, b=3, out_ready=1 -> each gives the listed {binv,sel}; cin equals binv; illegal=0.
- Illegal op: alu_op=11 -> sel=10, binv=0, illegal=1, delivered in order. Also alu_op=10 with funct 000000 -> illegal=1.
- Throughput: 100 back-to-back ops (a=i, b=2*i), out_ready=1 -> one op per cycle, in order, in_ready never drops, issued_cnt=100.
- Backpressure: out_ready=0 while 3 ops are offered -> 2 accepted, then in_ready=0; outputs hold op0. Raise out_ready -> op0, op1, op2 emerge in order with no loss or duplication.
- Counter wrap: CNT_W=4, 17 handshakes -> issued_cnt reads 1. Random valid/ready scoreboard run: output stream equals input stream exactly.
